esfa_op_controller: RTL

//  Upstream sequencer and downstream reducer for the ESFA cell array.

---
 rtl/esfa_op_controller.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/esfa_op_controller.sv
// ESFA cell-array controller: issues one op per request, snapshots cell responses and
// priority-reduces them chunk by chunk. Define ESFA_HITCOUNT_EN to enable the hit counter.
module esfa_op_controller #(
  parameter int unsigned N_CELLS = 8,
  parameter int unsigned SCAN_W  = 4,
  parameter int unsigned DW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DW-1:0]         req_index,
  input  logic [DW-1:0]         req_value,
  input  logic [DW-1:0]         req_meta,
  input  logic                  req_is_meta,
  output logic [7:0]            bc_selector,
  output logic [DW-1:0]         bc_index,
  output logic [DW-1:0]         bc_value,
  output logic [DW-1:0]         bc_meta,
  output logic                  bc_is_meta,
  input  logic [N_CELLS-1:0]    cell_bool,
  input  logic [N_CELLS*DW-1:0] cell_result,
  input  logic [N_CELLS*DW-1:0] cell_context,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic [7:0]            resp_handle,
  output logic [DW-1:0]         resp_value,
  output logic [DW-1:0]         resp_context,
  output logic [7:0]            resp_hit_count
);

  localparam logic [7:0] IdleSel = 8'h05;
  localparam int unsigned NChunks = N_CELLS / SCAN_W;
  localparam int unsigned ScanCntW = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam logic [ScanCntW-1:0] LastChunk = ScanCntW'(NChunks - 1);

  typedef enum logic [2:0] {StIdle, StIssue, StCapture, StScan, StResp} state_e;

  state_e                state_q, state_d;
  logic [7:0]            bc_selector_q, bc_selector_d;
  logic [DW-1:0]         bc_index_q, bc_index_d, bc_value_q, bc_value_d, bc_meta_q, bc_meta_d;
  logic                  bc_is_meta_q, bc_is_meta_d;
  logic [N_CELLS-1:0]    snap_bool_q, snap_bool_d;
  logic [N_CELLS*DW-1:0] snap_result_q, snap_result_d, snap_context_q, snap_context_d;
  logic [ScanCntW-1:0]   scan_q, scan_d;
  logic                  best_hit_q, best_hit_d;
  logic [7:0]            best_handle_q, best_handle_d;
  logic [DW-1:0]         best_value_q, best_value_d, best_context_q, best_context_d;
  logic                  resp_hit_q, resp_hit_d;
  logic [7:0]            resp_handle_q, resp_handle_d;
  logic [DW-1:0]         resp_value_q, resp_value_d, resp_context_q, resp_context_d;

  logic                  chunk_hit;
  logic [7:0]            chunk_handle;
  logic [DW-1:0]         chunk_value, chunk_context;

  // Running best merged with the current chunk; an earlier hit is never displaced.
  always_comb begin
    chunk_hit     = best_hit_q;
    chunk_handle  = best_handle_q;
    chunk_value   = best_value_q;
    chunk_context = best_context_q;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if ((i / SCAN_W) == 32'(scan_q) && !chunk_hit && snap_bool_q[i]) begin
        chunk_hit     = 1'b1;
        chunk_handle  = 8'(i);
        chunk_value   = snap_result_q[i*DW +: DW];
        chunk_context = snap_context_q[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    bc_selector_d  = IdleSel;
    bc_index_d     = '0;
    bc_value_d     = '0;
    bc_meta_d      = '0;
    bc_is_meta_d   = 1'b0;
    snap_bool_d    = snap_bool_q;
    snap_result_d  = snap_result_q;
    snap_context_d = snap_context_q;
    scan_d         = scan_q;
    best_hit_d     = best_hit_q;
    best_handle_d  = best_handle_q;
    best_value_d   = best_value_q;
    best_context_d = best_context_q;
    resp_hit_d     = resp_hit_q;
    resp_handle_d  = resp_handle_q;
    resp_value_d   = resp_value_q;
    resp_context_d = resp_context_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          bc_selector_d = {5'b0, req_op};
          bc_index_d    = req_index;
          bc_value_d    = req_value;
          bc_meta_d     = req_meta;
          bc_is_meta_d  = req_is_meta;
          state_d       = StIssue;
        end
      end
      StIssue: state_d = StCapture;
      StCapture: begin
        snap_bool_d    = cell_bool;
        snap_result_d  = cell_result;
        snap_context_d = cell_context;
        scan_d         = '0;
        best_hit_d     = 1'b0;
        best_handle_d  = '0;
        best_value_d   = '0;
        best_context_d = '0;
        state_d        = StScan;
      end
      StScan: begin
        best_hit_d     = chunk_hit;
        best_handle_d  = chunk_handle;
        best_value_d   = chunk_value;
        best_context_d = chunk_context;
        scan_d         = scan_q + 1'b1;
        if (scan_q == LastChunk) begin
          resp_hit_d     = chunk_hit;
          resp_handle_d  = chunk_handle;
          resp_value_d   = chunk_value;
          resp_context_d = chunk_context;
          state_d        = StResp;
        end
      end
      StResp: if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      bc_selector_q  <= IdleSel;
      bc_index_q     <= '0;
      bc_value_q     <= '0;
      bc_meta_q      <= '0;
      bc_is_meta_q   <= 1'b0;
      snap_bool_q    <= '0;
      snap_result_q  <= '0;
      snap_context_q <= '0;
      scan_q         <= '0;
      best_hit_q     <= 1'b0;
      best_handle_q  <= '0;
      best_value_q   <= '0;
      best_context_q <= '0;
      resp_hit_q     <= 1'b0;
      resp_handle_q  <= '0;
      resp_value_q   <= '0;
      resp_context_q <= '0;
    end else begin
      state_q        <= state_d;
      bc_selector_q  <= bc_selector_d;
      bc_index_q     <= bc_index_d;
      bc_value_q     <= bc_value_d;
      bc_meta_q      <= bc_meta_d;
      bc_is_meta_q   <= bc_is_meta_d;
      snap_bool_q    <= snap_bool_d;
      snap_result_q  <= snap_result_d;
      snap_context_q <= snap_context_d;
      scan_q         <= scan_d;
      best_hit_q     <= best_hit_d;
      best_handle_q  <= best_handle_d;
      best_value_q   <= best_value_d;
      best_context_q <= best_context_d;
      resp_hit_q     <= resp_hit_d;
      resp_handle_q  <= resp_handle_d;
      resp_value_q   <= resp_value_d;
      resp_context_q <= resp_context_d;
    end
  end

`ifdef ESFA_HITCOUNT_EN
  localparam int unsigned HcW = $clog2(N_CELLS + 1);

  logic [HcW-1:0] hit_cnt_q, hit_cnt_d, chunk_cnt;
  logic [7:0]     resp_hit_count_q, resp_hit_count_d;

  always_comb begin
    chunk_cnt = hit_cnt_q;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if ((i / SCAN_W) == 32'(scan_q)) chunk_cnt = chunk_cnt + HcW'(snap_bool_q[i]);
    end
    hit_cnt_d        = hit_cnt_q;
    resp_hit_count_d = resp_hit_count_q;
    if (state_q == StCapture) begin
      hit_cnt_d = '0;
    end else if (state_q == StScan) begin
      hit_cnt_d = chunk_cnt;
      if (scan_q == LastChunk) begin
        resp_hit_count_d = (32'(chunk_cnt) > 32'd255) ? 8'hFF : 8'(chunk_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q        <= '0;
      resp_hit_count_q <= '0;
    end else begin
      hit_cnt_q        <= hit_cnt_d;
      resp_hit_count_q <= resp_hit_count_d;
    end
  end

  assign resp_hit_count = resp_hit_count_q;
`else
  assign resp_hit_count = 8'h00;
`endif

  assign req_ready    = (state_q == StIdle);
  assign resp_valid   = (state_q == StResp);
  assign bc_selector  = bc_selector_q;
  assign bc_index     = bc_index_q;
  assign bc_value     = bc_value_q;
  assign bc_meta      = bc_meta_q;
  assign bc_is_meta   = bc_is_meta_q;
  assign resp_hit     = resp_hit_q;
  assign resp_handle  = resp_handle_q;
  assign resp_value   = resp_value_q;
  assign resp_context = resp_context_q;

endmodule
